host_frame_receiver: RTL and testbench



---
 rtl/host_frame_receiver_pkg.sv | 16 +
 rtl/host_frame_receiver_timeout.sv | 34 +++
 rtl/host_frame_receiver.sv | 163 ++++++++++++++++
 tb/tb_host_frame_receiver.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/host_frame_receiver_pkg.sv
// Shared definitions for the host frame receiver: state encodings,
// frame geometry and the default inter-byte timeout.
package host_frame_receiver_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA    = 3'd1,
        CHECK   = 3'd2,
        HOLD    = 3'd3,
        RELEASE = 3'd4
    } rxStateT;

    localparam int FRAME_DATA_BYTES       = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/host_frame_receiver_timeout.sv
// Inter-byte timeout counter. Counts enabled cycles since the last clear and
// flags expiry on the cycle the count reaches TIMEOUT_CYCLES-1 while enabled.
module frame_timeout_counter
    import host_frame_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic masterClock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tcnt;

    // Count idle cycles; any byte (clear) restarts the window.
    always_ff @(posedge masterClock) begin
        if (!reset || clear) begin
            tcnt <= '0;
        end else if (enable) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Expiry is judged on the cycle that would count past the limit.
    always_comb begin
        expired = enable && (tcnt == LAST);
    end

endmodule

// File: rtl/host_frame_receiver.sv
// Host frame receiver: assembles control byte + 32-bit word (MSB byte first)
// from the UART byte stream and hands it to the sandbox process with a
// dataReceived / clearDR handshake. Detects inter-byte timeout and overrun.
// Optional feature macro: FRAME_CHECKSUM_EN (adds a trailing XOR checksum byte).
module host_frame_receiver
    import host_frame_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        masterClock,
    input  logic        reset,
    input  logic        rxValid,
    input  logic [7:0]  rxByte,
    input  logic        clearDR,
    output logic        dataReceived,
    output logic [7:0]  control,
    output logic [31:0] inputData,
    output logic        overrun,
    output logic        frameError
);

    localparam logic [1:0] LAST_IDX = 2'(FRAME_DATA_BYTES - 1);

    rxStateT    state;
    rxStateT    nextState;
    logic [1:0] idx;
    logic [1:0] lane;
    logic       inFrame;
    logic       expired;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0] xorAcc;
`endif

    // Timeout only runs while a frame is partially assembled.
    always_comb begin
        inFrame = (state == DATA);
`ifdef FRAME_CHECKSUM_EN
        inFrame = (state == DATA) || (state == CHECK);
`endif
        lane    = LAST_IDX - idx;
    end

    frame_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) timeoutCounter (
        .masterClock (masterClock),
        .reset       (reset),
        .clear       (rxValid || !inFrame),
        .enable      (inFrame && !rxValid),
        .expired     (expired)
    );

    // State register.
    always_ff @(posedge masterClock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (rxValid) nextState = DATA;
            end
            DATA: begin
                if (rxValid) begin
                    if (idx == LAST_IDX) begin
`ifdef FRAME_CHECKSUM_EN
                        nextState = CHECK;
`else
                        nextState = HOLD;
`endif
                    end
                end else if (expired) begin
                    nextState = IDLE;
                end
            end
`ifdef FRAME_CHECKSUM_EN
            CHECK: begin
                if (rxValid) begin
                    nextState = (rxByte == xorAcc) ? HOLD : IDLE;
                end else if (expired) begin
                    nextState = IDLE;
                end
            end
`endif
            HOLD: begin
                if (clearDR) nextState = RELEASE;
            end
            RELEASE: begin
                if (!clearDR) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Registered outputs and frame datapath; pulses default low every cycle.
    always_ff @(posedge masterClock) begin
        if (!reset) begin
            dataReceived <= 1'b0;
            control      <= '0;
            inputData    <= '0;
            overrun      <= 1'b0;
            frameError   <= 1'b0;
            idx          <= '0;
`ifdef FRAME_CHECKSUM_EN
            xorAcc       <= '0;
`endif
        end else begin
            overrun    <= 1'b0;
            frameError <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxValid) begin
                        control <= rxByte;
                        idx     <= '0;
`ifdef FRAME_CHECKSUM_EN
                        xorAcc  <= rxByte;
`endif
                    end
                end
                DATA: begin
                    if (rxValid) begin
                        inputData[{lane, 3'b000} +: 8] <= rxByte;
`ifdef FRAME_CHECKSUM_EN
                        xorAcc <= xorAcc ^ rxByte;
                        if (idx != LAST_IDX) idx <= idx + 1'b1;
`else
                        if (idx == LAST_IDX) dataReceived <= 1'b1;
                        else                 idx <= idx + 1'b1;
`endif
                    end else if (expired) begin
                        frameError <= 1'b1;
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                CHECK: begin
                    if (rxValid) begin
                        if (rxByte == xorAcc) dataReceived <= 1'b1;
                        else                  frameError   <= 1'b1;
                    end else if (expired) begin
                        frameError <= 1'b1;
                    end
                end
`endif
                HOLD: begin
                    // clearDR wins over a coincident byte; the byte is still dropped.
                    if (rxValid) overrun <= 1'b1;
                    if (clearDR) dataReceived <= 1'b0;
                end
                RELEASE: begin
                    if (rxValid) overrun <= 1'b1;
                end
                default: dataReceived <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_host_frame_receiver.sv
// Scoreboard bench for host_frame_receiver: stimulus pushes expected frame,
// overrun and frameError events; a monitor pops them as the DUT emits them.
module tb_host_frame_receiver;

    localparam int TMO = 16;
    localparam int EV_FRAME = 0;
    localparam int EV_OVR   = 1;
    localparam int EV_ERR   = 2;

    typedef struct {
        int          kind;
        logic [7:0]  ctl;
        logic [31:0] data;
    } expEvT;

    logic        masterClock = 1'b0;
    logic        reset = 1'b0;
    logic        rxValid = 1'b0;
    logic [7:0]  rxByte = '0;
    logic        clearDR = 1'b0;
    logic        dataReceived;
    logic [7:0]  control;
    logic [31:0] inputData;
    logic        overrun;
    logic        frameError;

    int checks = 0;
    int failures = 0;
    expEvT expQ[$];

    host_frame_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
        .masterClock  (masterClock),
        .reset        (reset),
        .rxValid      (rxValid),
        .rxByte       (rxByte),
        .clearDR      (clearDR),
        .dataReceived (dataReceived),
        .control      (control),
        .inputData    (inputData),
        .overrun      (overrun),
        .frameError   (frameError)
    );

    always #5 masterClock = ~masterClock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge masterClock);
            #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        rxValid = 1'b1;
        rxByte  = b;
        tick();
        rxValid = 1'b0;
        tick(gap);
    endtask

    task automatic expectEv(input int kind, input logic [7:0] c, input logic [31:0] d);
        expEvT e;
        e.kind = kind;
        e.ctl  = c;
        e.data = d;
        expQ.push_back(e);
    endtask

    // Sends a complete frame; last strobe has no trailing gap so the caller
    // can check the one-cycle dataReceived latency.
    task automatic sendFrame(input logic [7:0] c, input logic [31:0] d, input int gap);
        logic [7:0] sum;
        sum = c ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
        sendByte(c, gap);
        sendByte(d[31:24], gap);
        sendByte(d[23:16], gap);
        sendByte(d[15:8], gap);
`ifdef FRAME_CHECKSUM_EN
        sendByte(d[7:0], gap);
        sendByte(sum, 0);
`else
        sendByte(d[7:0], 0);
`endif
    endtask

    task automatic release3;
        clearDR = 1'b1;
        tick();
        check("dr_low_after_clear", 32'(dataReceived), 32'd0);
        tick(2);
        clearDR = 1'b0;
        tick(2);
    endtask

    // Monitor: every DUT event must match the head of the scoreboard.
    logic        prevDR = 1'b0;
    logic        holdChanged = 1'b0;
    logic [7:0]  heldCtl;
    logic [31:0] heldData;
    always @(negedge masterClock) begin
        if (dataReceived && !prevDR) begin
            heldCtl = control;
            heldData = inputData;
            holdChanged = 1'b0;
            if (expQ.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_frame: got ctl=0x%0h data=0x%0h expected no event", control, inputData);
            end else begin
                expEvT e;
                e = expQ.pop_front();
                check("frame_kind", 32'(EV_FRAME), 32'(e.kind));
                check("frame_control", 32'(control), 32'(e.ctl));
                check("frame_inputData", inputData, e.data);
            end
        end
        if (dataReceived && prevDR && (control !== heldCtl || inputData !== heldData))
            holdChanged = 1'b1;
        if (!dataReceived && prevDR)
            check("hold_stable", 32'(holdChanged), 32'd0);
        if (overrun || frameError) begin
            if (expQ.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_pulse: got ovr=%0b err=%0b expected none", overrun, frameError);
            end else begin
                expEvT e;
                e = expQ.pop_front();
                check("pulse_kind", 32'(overrun ? EV_OVR : EV_ERR), 32'(e.kind));
            end
        end
        prevDR = dataReceived;
    end

    initial begin
        // Reset state.
        reset = 1'b0;
        tick(3);
        check("rst_dataReceived", 32'(dataReceived), 32'd0);
        check("rst_control", 32'(control), 32'd0);
        check("rst_inputData", inputData, 32'd0);
        check("rst_pulses", {30'd0, overrun, frameError}, 32'd0);
        reset = 1'b1;
        tick(2);

        // Frame 1, one byte every 10 cycles, then hold for 1000 cycles.
        expectEv(EV_FRAME, 8'hA5, 32'h12345678);
        sendFrame(8'hA5, 32'h12345678, 9);
        check("dr_latency", 32'(dataReceived), 32'd1);
        tick(1000);
        check("dr_held", 32'(dataReceived), 32'd1);
        check("held_inputData", inputData, 32'h12345678);
        release3();

        // Frame 2 after release.
        expectEv(EV_FRAME, 8'h01, 32'hDEADBEEF);
        sendFrame(8'h01, 32'hDEADBEEF, 0);
        check("f2_dr", 32'(dataReceived), 32'd1);
        tick(3);

        // Overrun during hold; contents unchanged, no extra frame later.
        expectEv(EV_OVR, 8'h00, 32'h0);
        sendByte(8'h55, 1);
        check("ovr_control", 32'(control), 32'h01);
        check("ovr_inputData", inputData, 32'hDEADBEEF);
        release3();
        tick(20);
        check("no_extra_frame", 32'(dataReceived), 32'd0);

        // Coincident byte and clearDR in HOLD: clear wins, byte dropped.
        expectEv(EV_FRAME, 8'h33, 32'hCAFEF00D);
        sendFrame(8'h33, 32'hCAFEF00D, 0);
        expectEv(EV_OVR, 8'h00, 32'h0);
        rxValid = 1'b1; rxByte = 8'h77; clearDR = 1'b1;
        tick();
        rxValid = 1'b0;
        check("coincident_dr", 32'(dataReceived), 32'd0);
        clearDR = 1'b0;
        tick(2);

        // Timeout: 2 bytes then 16 idle cycles.
        sendByte(8'h09, 0);
        sendByte(8'h99, 0);
        expectEv(EV_ERR, 8'h00, 32'h0);
        tick(TMO - 1);
        check("tmo_not_yet", 32'(frameError), 32'd0);
        tick();
        check("tmo_pulse", 32'(frameError), 32'd1);
        check("tmo_dr", 32'(dataReceived), 32'd0);
        tick(2);
        expectEv(EV_FRAME, 8'h02, 32'h00000001);
        sendFrame(8'h02, 32'h00000001, 2);
        check("post_tmo_dr", 32'(dataReceived), 32'd1);
        release3();

        // Reset mid-frame, then a full frame.
        sendByte(8'hF0, 0);
        sendByte(8'hF1, 0);
        sendByte(8'hF2, 0);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(TMO + 4);
        check("rst_mid_dr", 32'(dataReceived), 32'd0);
        expectEv(EV_FRAME, 8'h5A, 32'h0BADC0DE);
        sendFrame(8'h5A, 32'h0BADC0DE, 0);
        check("rst_mid_frame_dr", 32'(dataReceived), 32'd1);
        release3();

`ifdef FRAME_CHECKSUM_EN
        // Good checksum 0x54, then bad checksum 0x00.
        expectEv(EV_FRAME, 8'h10, 32'h11223344);
        sendByte(8'h10, 0); sendByte(8'h11, 0); sendByte(8'h22, 0);
        sendByte(8'h33, 0); sendByte(8'h44, 0); sendByte(8'h54, 0);
        check("cks_good_dr", 32'(dataReceived), 32'd1);
        release3();
        expectEv(EV_ERR, 8'h00, 32'h0);
        sendByte(8'h10, 0); sendByte(8'h11, 0); sendByte(8'h22, 0);
        sendByte(8'h33, 0); sendByte(8'h44, 0); sendByte(8'h00, 0);
        check("cks_bad_err", 32'(frameError), 32'd1);
        check("cks_bad_dr", 32'(dataReceived), 32'd0);
        tick(3);
`endif

        tick(5);
        check("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
